// File: rtl/apb_req_arbiter_if.sv
// Requester-side and APB-master-side signal bundle for apb_req_arbiter.
// The wait_cnt output is present only when APB_ARB_WAITCNT_EN is defined.
interface apb_req_arbiter_if #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32
);
  localparam int unsigned AW = ADDWIDTH + 1;
  localparam int unsigned SW = DATAWIDTH / 8;

  // requester side
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           req_write;
  logic [NREQ*AW-1:0]        req_addr;
  logic [NREQ*DATAWIDTH-1:0] req_wdata;
  logic [NREQ*SW-1:0]        req_strb;
  logic [NREQ-1:0]           ack;
  logic [DATAWIDTH-1:0]      rdata;
  logic [1:0]                grant_id;
  logic                      busy;
`ifdef APB_ARB_WAITCNT_EN
  logic [15:0]               wait_cnt;
`endif

  // APB master side
  logic                      transfer;
  logic                      PWRITEin;
  logic [AW-1:0]             PADDRin;
  logic [DATAWIDTH-1:0]      PWDATAin;
  logic [SW-1:0]             PSTRBin;
  logic                      PREADY;
  logic [DATAWIDTH-1:0]      PRDATA;

  // arbiter view
  modport slave (
    input  req, req_write, req_addr, req_wdata, req_strb, PREADY, PRDATA,
    output ack, rdata, grant_id, busy, transfer, PWRITEin, PADDRin, PWDATAin, PSTRBin
`ifdef APB_ARB_WAITCNT_EN
    , output wait_cnt
`endif
  );

  // requesters plus master view
  modport master (
    output req, req_write, req_addr, req_wdata, req_strb, PREADY, PRDATA,
    input  ack, rdata, grant_id, busy, transfer, PWRITEin, PADDRin, PWDATAin, PSTRBin
`ifdef APB_ARB_WAITCNT_EN
    , input wait_cnt
`endif
  );
endinterface

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NREQ requesters, tracking the
// master's IDLE/SETUP/ACCESS phases. Optional wait-state counter: APB_ARB_WAITCNT_EN.
module apb_req_arbiter #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDWIDTH  = 8,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_req_arbiter_if.slave  bus
);

  localparam int unsigned AW = ADDWIDTH + 1;
  localparam int unsigned SW = DATAWIDTH / 8;
  localparam int unsigned IW = 2;
`ifdef APB_ARB_WAITCNT_EN
  localparam int unsigned CW = 16;
`endif

  typedef enum logic [1:0] {
    A_IDLE   = 2'd0,
    A_START  = 2'd1,
    A_SETUP  = 2'd2,
    A_ACCESS = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [IW-1:0]        ptr_q,      ptr_d;
  logic [IW-1:0]        gid_q,      gid_d;
  logic                 busy_q,     busy_d;
  logic                 transfer_q, transfer_d;
  logic                 pwrite_q,   pwrite_d;
  logic [AW-1:0]        paddr_q,    paddr_d;
  logic [DATAWIDTH-1:0] pwdata_q,   pwdata_d;
  logic [SW-1:0]        pstrb_q,    pstrb_d;
  logic [DATAWIDTH-1:0] rdata_q,    rdata_d;
  logic [NREQ-1:0]      ack_q,      ack_d;
`ifdef APB_ARB_WAITCNT_EN
  logic [CW-1:0]        wcnt_q,     wcnt_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
`endif

  logic                 complete_c;
  logic [NREQ-1:0]      mask_c;
  logic [NREQ-1:0]      elig_c;
  logic                 found_c;
  logic [IW-1:0]        win_c;
  logic [IW-1:0]        nxt_ptr_c;
  logic                 load_c;

  // The grantee stays masked through its completion and ack cycles.
  assign complete_c = (state_q == A_ACCESS) && bus.PREADY;
  assign mask_c     = complete_c ? (NREQ'(1) << gid_q) : ack_q;
  assign elig_c     = bus.req & ~mask_c;

  // First eligible requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found_c && ((elig_c >> idx) & NREQ'(1)) != '0) begin
        found_c = 1'b1;
        win_c   = IW'(idx);
      end
    end
  end

  assign nxt_ptr_c = ((32'(win_c) + 32'd1) >= NREQ) ? '0 : (win_c + IW'(1));

  // Tracker next state, operand latching and completion handling.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    busy_d     = busy_q;
    transfer_d = transfer_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    rdata_d    = rdata_q;
    ack_d      = '0;
    load_c     = 1'b0;
`ifdef APB_ARB_WAITCNT_EN
    wcnt_d     = wcnt_q;
    wait_cnt_d = wait_cnt_q;
`endif

    case (state_q)
      A_IDLE: begin
        if (found_c) begin
          load_c  = 1'b1;
          state_d = A_START;
        end
      end
      A_START: state_d = A_SETUP;
      A_SETUP: state_d = A_ACCESS;
      A_ACCESS: begin
        if (bus.PREADY) begin
          rdata_d = bus.PRDATA;
          ack_d   = NREQ'(1) << gid_q;
`ifdef APB_ARB_WAITCNT_EN
          wait_cnt_d = wcnt_q;
`endif
          // Back-to-back: master goes ACCESS -> SETUP with transfer held high.
          if (found_c) begin
            load_c  = 1'b1;
            state_d = A_SETUP;
          end else begin
            state_d    = A_IDLE;
            busy_d     = 1'b0;
            transfer_d = 1'b0;
          end
        end else begin
`ifdef APB_ARB_WAITCNT_EN
          if (wcnt_q != '1) wcnt_d = wcnt_q + CW'(1);
`endif
        end
      end
      default: state_d = A_IDLE;
    endcase

    if (load_c) begin
      gid_d      = win_c;
      ptr_d      = nxt_ptr_c;
      busy_d     = 1'b1;
      transfer_d = 1'b1;
      pwrite_d   = |(bus.req_write & (NREQ'(1) << win_c));
      paddr_d    = AW'(bus.req_addr >> (32'(win_c) * AW));
      pwdata_d   = DATAWIDTH'(bus.req_wdata >> (32'(win_c) * DATAWIDTH));
      pstrb_d    = SW'(bus.req_strb >> (32'(win_c) * SW));
`ifdef APB_ARB_WAITCNT_EN
      wcnt_d     = '0;
`endif
    end
  end

  // Reset aborts any transfer in flight without an ack.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= A_IDLE;
      ptr_q      <= '0;
      gid_q      <= '0;
      busy_q     <= 1'b0;
      transfer_q <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
`ifdef APB_ARB_WAITCNT_EN
      wcnt_q     <= '0;
      wait_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gid_q      <= gid_d;
      busy_q     <= busy_d;
      transfer_q <= transfer_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
`ifdef APB_ARB_WAITCNT_EN
      wcnt_q     <= wcnt_d;
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.transfer = transfer_q;
  assign bus.PWRITEin = pwrite_q;
  assign bus.PADDRin  = paddr_q;
  assign bus.PWDATAin = pwdata_q;
  assign bus.PSTRBin  = pstrb_q;
`ifdef APB_ARB_WAITCNT_EN
  assign bus.wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus random traffic checked every
// cycle against a transaction-timeline reference model (NREQ=2), and an NREQ=3 instance.
module tb_apb_req_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 32;
  localparam int unsigned SW   = 4;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_req_arbiter_if #(.NREQ(2), .ADDWIDTH(8), .DATAWIDTH(32)) bus  ();
  apb_req_arbiter_if #(.NREQ(3), .ADDWIDTH(8), .DATAWIDTH(32)) bus3 ();

  apb_req_arbiter #(.NREQ(2), .ADDWIDTH(8), .DATAWIDTH(32)) dut  (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));
  apb_req_arbiter #(.NREQ(3), .ADDWIDTH(8), .DATAWIDTH(32)) dut3 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus3));

  int total = 0;
  int bad   = 0;

  // requester operand registers
  logic          r_req   [NREQ];
  logic          r_wr    [NREQ];
  logic [AW-1:0] r_addr  [NREQ];
  logic [DW-1:0] r_wdata [NREQ];
  logic [SW-1:0] r_strb  [NREQ];

  // reference model: timeline of the transfer in flight
  int          cyc;
  bit          own;
  int          owner, acc_start, ack_cyc, ack_who, ptr, last_gid, exp_wait;
  logic [DW-1:0] exp_rdata;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;
  int ack_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    logic [NREQ-1:0]    rq, wr;
    logic [NREQ*AW-1:0] ad;
    logic [NREQ*DW-1:0] wd;
    logic [NREQ*SW-1:0] st;
    rq = '0; wr = '0; ad = '0; wd = '0; st = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq |= NREQ'(r_req[i]) << i;
      wr |= NREQ'(r_wr[i]) << i;
      ad |= (NREQ*AW)'(r_addr[i]) << (i * AW);
      wd |= (NREQ*DW)'(r_wdata[i]) << (i * DW);
      st |= (NREQ*SW)'(r_strb[i]) << (i * SW);
    end
    bus.req = rq; bus.req_write = wr; bus.req_addr = ad; bus.req_wdata = wd; bus.req_strb = st;
  endtask

  task automatic model_reset();
    own = 0; owner = 0; acc_start = 0; ack_cyc = -10; ack_who = 0;
    ptr = 0; last_gid = 0; exp_wait = 0; cyc = 0; exp_rdata = '0;
  endtask

  // Consumes this cycle's inputs and predicts the next cycle.
  task automatic model_update();
    logic [NREQ-1:0] elig;
    bit done;
    int w;
    done = own && (cyc >= acc_start) && (bus.PREADY === 1'b1);
    if (done) begin
      ack_cyc   = cyc + 1;
      ack_who   = owner;
      exp_rdata = bus.PRDATA;
      exp_wait  = (cyc - acc_start > 65535) ? 65535 : cyc - acc_start;
    end
    if (!own || done) begin
      elig = bus.req;
      if (done) elig &= ~(NREQ'(1) << owner);
      else if (cyc == ack_cyc) elig &= ~(NREQ'(1) << ack_who);
      w = -1;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (ptr + k) % NREQ;
        if (w < 0 && ((elig >> c) & 1) != 0) w = c;
      end
      if (w >= 0) begin
        own = 1; owner = w; last_gid = w; ptr = (w + 1) % NREQ;
        acc_start = done ? cyc + 2 : cyc + 3;
        m_wr = r_wr[w]; m_addr = r_addr[w]; m_wdata = r_wdata[w]; m_strb = r_strb[w];
      end else begin
        own = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NREQ-1:0] ea;
    ea = (cyc == ack_cyc) ? (NREQ'(1) << ack_who) : '0;
    chk("ack", 64'(bus.ack), 64'(ea));
    chk("busy", 64'(bus.busy), 64'(own));
    chk("transfer", 64'(bus.transfer), 64'(own));
    chk("grant_id", 64'(bus.grant_id), 64'(last_gid));
    if (cyc == ack_cyc) begin
      chk("rdata", 64'(bus.rdata), 64'(exp_rdata));
`ifdef APB_ARB_WAITCNT_EN
      chk("wait_cnt", 64'(bus.wait_cnt), 64'(exp_wait));
`endif
    end
    if (own) begin
      chk("PWRITEin", 64'(bus.PWRITEin), 64'(m_wr));
      chk("PADDRin", 64'(bus.PADDRin), 64'(m_addr));
      chk("PWDATAin", 64'(bus.PWDATAin), 64'(m_wdata));
      chk("PSTRBin", 64'(bus.PSTRBin), 64'(m_strb));
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge PCLK);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) r_req[i] = 1'b0;
    apply();
    bus3.req = '0;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    model_reset();
    check_outputs();
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_paddr", 64'(bus.PADDRin), 64'd0);
    chk("rst_pwdata", 64'(bus.PWDATAin), 64'd0);
    chk("rst_pstrb", 64'(bus.PSTRBin), 64'd0);
    chk("rst_pwrite", 64'(bus.PWRITEin), 64'd0);
`ifdef APB_ARB_WAITCNT_EN
    chk("rst_wait_cnt", 64'(bus.wait_cnt), 64'd0);
`endif
  endtask

  task automatic rand_ops(input int i);
    r_wr[i] = 1'($urandom); r_addr[i] = AW'($urandom);
    r_wdata[i] = $urandom; r_strb[i] = SW'($urandom);
  endtask

  // Logs acks; requester either drops or immediately re-requests with new operands.
  task automatic handle_acks(input bit keep);
    for (int i = 0; i < NREQ; i++) begin
      if (((bus.ack >> i) & 1) != 0) begin
        ack_log.push_back(i);
        if (keep) rand_ops(i);
        else r_req[i] = 1'b0;
      end
    end
    apply();
  endtask

  initial begin
    int budget;
    int order3[$];
    for (int i = 0; i < NREQ; i++) begin
      r_req[i] = 0; r_wr[i] = 0; r_addr[i] = '0; r_wdata[i] = '0; r_strb[i] = '0;
    end
    bus.PREADY = 1'b0; bus.PRDATA = '0;
    bus3.req = '0; bus3.req_write = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
    bus3.req_strb = '0; bus3.PREADY = 1'b1; bus3.PRDATA = 32'h0000_3333;
    apply();
    model_reset();
    repeat (2) @(posedge PCLK);

    // single read
    do_reset();
    r_req[0] = 1; r_wr[0] = 0; r_addr[0] = 9'h105; apply();
    bus.PREADY = 1'b1; bus.PRDATA = 32'hDEADBEEF;
    tick();
    chk("t1_transfer_c1", 64'(bus.transfer), 64'd1);
    chk("t1_paddr", 64'(bus.PADDRin), 64'h105);
    tick(); tick();
    chk("t1_transfer_c3", 64'(bus.transfer), 64'd1);
    tick();
    chk("t1_ack_c4", 64'(bus.ack), 64'b01);
    chk("t1_rdata", 64'(bus.rdata), 64'hDEADBEEF);
    r_req[0] = 0; apply();
    tick();
    chk("t1_idle", 64'(bus.transfer), 64'd0);

    // wait states: three ACCESS cycles with PREADY low
    r_req[0] = 1; r_wr[0] = 1; r_addr[0] = 9'h020; r_wdata[0] = 32'h12345678; r_strb[0] = 4'hF;
    apply(); bus.PREADY = 1'b0;
    repeat (6) tick();
    bus.PREADY = 1'b1;
    chk("t2_paddr_hold", 64'(bus.PADDRin), 64'h020);
    chk("t2_no_ack", 64'(bus.ack), 64'd0);
    tick();
    chk("t2_ack", 64'(bus.ack), 64'b01);
`ifdef APB_ARB_WAITCNT_EN
    chk("t2_wait_cnt", 64'(bus.wait_cnt), 64'd3);
`endif
    r_req[0] = 0; apply();
    tick();

    // contention from reset: 0 then 1, transfer never drops
    do_reset();
    ack_log.delete();
    r_req[0] = 1; r_req[1] = 1; rand_ops(0); rand_ops(1); apply();
    bus.PREADY = 1'b1; bus.PRDATA = 32'hCAFE0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c <= 5) chk("t3_transfer_held", 64'(bus.transfer), 64'd1);
      bus.PRDATA = $urandom;
      handle_acks(1'b0);
    end
    chk("t3_ack_count", 64'(ack_log.size()), 64'd2);
    if (ack_log.size() == 2) begin
      chk("t3_first", 64'(ack_log[0]), 64'd0);
      chk("t3_second", 64'(ack_log[1]), 64'd1);
    end

    // fairness: both continuously requesting
    do_reset();
    ack_log.delete();
    r_req[0] = 1; r_req[1] = 1; rand_ops(0); rand_ops(1); apply();
    budget = 300;
    while (ack_log.size() < 8 && budget > 0) begin
      bus.PREADY = ($urandom_range(0, 9) < 6); bus.PRDATA = $urandom;
      tick();
      handle_acks(1'b1);
      budget--;
    end
    if (budget == 0) chk("t4_timeout", 64'(ack_log.size()), 64'd8);
    for (int j = 0; j < ack_log.size() && j < 8; j++)
      chk("t4_alternate", 64'(ack_log[j]), 64'(j % 2));
    for (int i = 0; i < NREQ; i++) r_req[i] = 0;
    apply(); bus.PREADY = 1'b1;
    repeat (8) tick();

    // reset during ACCESS
    do_reset();
    r_req[0] = 1; rand_ops(0); apply(); bus.PREADY = 1'b0;
    repeat (4) tick();
    do_reset();
    chk("t5_no_ack", 64'(bus.ack), 64'd0);
    repeat (3) tick();
    r_req[1] = 1; rand_ops(1); apply(); bus.PREADY = 1'b1; bus.PRDATA = 32'h0BAD_F00D;
    repeat (4) tick();
    chk("t5_regrant_ack", 64'(bus.ack), 64'b10);
    r_req[1] = 0; apply();
    tick();

    // NREQ=3: pointer at 1 after serving requester 0, then 3'b101
    do_reset();
    bus3.req = 3'b001; bus3.req_addr = {9'h0C2, 9'h0B1, 9'h0A0};
    budget = 12;
    while (bus3.ack == 3'b000 && budget > 0) begin tick(); budget--; end
    chk("t6_first_ack", 64'(bus3.ack), 64'b001);
    bus3.req = 3'b000;
    tick();
    bus3.req = 3'b101;
    tick();
    chk("t6_grant_id", 64'(bus3.grant_id), 64'd2);
    chk("t6_paddr", 64'(bus3.PADDRin), 64'h0C2);
    budget = 20;
    while (order3.size() < 2 && budget > 0) begin
      tick();
      if (bus3.ack == 3'b100) begin order3.push_back(2); bus3.req = bus3.req & 3'b011; end
      if (bus3.ack == 3'b001) begin order3.push_back(0); bus3.req = bus3.req & 3'b110; end
      budget--;
    end
    chk("t6_ack_count", 64'(order3.size()), 64'd2);
    if (order3.size() == 2) begin
      chk("t6_order_a", 64'(order3[0]), 64'd2);
      chk("t6_order_b", 64'(order3[1]), 64'd0);
    end
    bus3.req = 3'b000;

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (((bus.ack >> i) & 1) != 0) begin
          r_req[i] = 1'($urandom);
          rand_ops(i);
        end else if (!r_req[i] && $urandom_range(0, 3) == 0) begin
          r_req[i] = 1'b1;
          rand_ops(i);
        end
      end
      apply();
      bus.PREADY = ($urandom_range(0, 9) < 6);
      bus.PRDATA = $urandom;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
